// File: rtl/cache_main_memory_if.sv
// Block-level memory bus between the data cache (master) and main memory (slave).
// Requests are level-held; busywait stalls the cache until the access completes.
interface cache_main_memory_if #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
);
  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;
  logic               mem_err;

  modport master (
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait, mem_err
  );
endinterface

// File: rtl/cache_main_memory.sv
// Main-memory responder for the data cache: one block read/write at a time,
// fixed access latency, block storage in an internal array.
module cache_main_memory #(
  parameter int ADDR_W     = 28,
  parameter int BLOCK_W    = 128,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 5
) (
  input  logic               clk,
  input  logic               reset,
  cache_main_memory_if.slave bus
);
  localparam int         DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [7:0]            count_reg;
  logic [DEPTH_LOG2-1:0] idx_reg;
  logic [BLOCK_W-1:0]    wdata_reg;
  logic [BLOCK_W-1:0]    rdata_reg;
  logic                  write_reg;
  logic                  err_reg;
  logic                  request;
  logic                  accept;
  logic                  complete;
  logic [BLOCK_W-1:0]    mem_array [DEPTH];

  // Upper address bits deliberately alias onto the same array entries.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.mem_address[ADDR_W-1:DEPTH_LOG2];

  assign request = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (request) state_next = BUSY;
      BUSY:    if (count_reg == 8'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept           = 1'b0;
    complete         = 1'b0;
    bus.mem_busywait = 1'b0;
    bus.mem_err      = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.mem_busywait = request;
        accept           = request;
      end
      BUSY: begin
        bus.mem_busywait = 1'b1;
        complete         = (count_reg == 8'd0);
      end
      DONE:    bus.mem_err = err_reg;
      default: ;
    endcase
  end

  assign bus.mem_readdata = rdata_reg;

  // Request fields are latched at acceptance; inputs are ignored while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= 8'd0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        count_reg <= COUNT_LOAD;
        idx_reg   <= bus.mem_address[DEPTH_LOG2-1:0];
        wdata_reg <= bus.mem_writedata;
        write_reg <= bus.mem_write;
        err_reg   <= bus.mem_read & bus.mem_write;
      end else if (state_reg == BUSY && count_reg != 8'd0) begin
        count_reg <= count_reg - 8'd1;
      end
      if (complete && !write_reg) rdata_reg <= mem_array[idx_reg];
      if (state_reg == DONE) err_reg <= 1'b0;
    end
  end

  // Array has no reset so contents survive; complete is low while in reset.
  always_ff @(posedge clk) begin
    if (complete && write_reg) mem_array[idx_reg] <= wdata_reg;
  end
endmodule

// File: tb/tb_cache_main_memory.sv
// Bench for cache_main_memory: two instances (latency 5 and 1) share request
// inputs and are checked against a transaction-level memory model.
module tb_cache_main_memory;
  logic         clk;
  logic         reset;
  logic         req_rd;
  logic         req_wr;
  logic [27:0]  req_addr;
  logic [127:0] req_data;

  int errors = 0;
  int checks = 0;

  logic [127:0] model_mem [int];
  int           written_q [$];

  cache_main_memory_if #(.ADDR_W(28), .BLOCK_W(128)) bus5 ();
  cache_main_memory_if #(.ADDR_W(28), .BLOCK_W(128)) bus1 ();

  assign bus5.mem_read      = req_rd;
  assign bus5.mem_write     = req_wr;
  assign bus5.mem_address   = req_addr;
  assign bus5.mem_writedata = req_data;
  assign bus1.mem_read      = req_rd;
  assign bus1.mem_write     = req_wr;
  assign bus1.mem_address   = req_addr;
  assign bus1.mem_writedata = req_data;

  cache_main_memory #(.ADDR_W(28), .BLOCK_W(128), .DEPTH_LOG2(8), .LATENCY(5)) dut5 (
    .clk(clk), .reset(reset), .bus(bus5)
  );
  cache_main_memory #(.ADDR_W(28), .BLOCK_W(128), .DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input int lat);
    return (lat == 1) ? bus1.mem_busywait : bus5.mem_busywait;
  endfunction

  function automatic logic err_of(input int lat);
    return (lat == 1) ? bus1.mem_err : bus5.mem_err;
  endfunction

  function automatic logic [127:0] rdata_of(input int lat);
    return (lat == 1) ? bus1.mem_readdata : bus5.mem_readdata;
  endfunction

  // One complete access observed on the instance with latency lat.
  task automatic do_access(input int lat, input logic rd, input logic wr,
                           input logic [27:0] addr, input logic [127:0] data,
                           input string tag, output logic [127:0] rdata);
    int idx;
    int n;
    bit done;
    idx  = int'(addr % 28'd256);
    done = 1'b0;
    @(negedge clk);
    req_rd = rd; req_wr = wr; req_addr = addr; req_data = data;
    #1;
    n = busy_of(lat) ? 1 : 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (!busy_of(lat)) begin
        done = 1'b1;
        break;
      end
      n++;
    end
    if (!done) check_eq({tag, "_timeout"}, 128'(busy_of(lat)), 128'(0));
    rdata = rdata_of(lat);
    check_eq({tag, "_busy_cycles"}, 128'(n), 128'(lat + 1));
    check_eq({tag, "_err"}, 128'(err_of(lat)), 128'(rd & wr));
    if (rd && !wr && model_mem.exists(idx))
      check_eq({tag, "_rdata"}, rdata, model_mem[idx]);
    if (wr) begin
      if (!model_mem.exists(idx)) written_q.push_back(idx);
      model_mem[idx] = data;
    end
    $display("txn %s lat=%0d rd=%0b wr=%0b addr=%h busy_cycles=%0d rdata=%h",
             tag, lat, rd, wr, addr, n, rdata);
    req_rd = 1'b0; req_wr = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_err_cleared"}, 128'(err_of(lat)), 128'(0));
    repeat (6) @(posedge clk);
  endtask

  initial begin
    logic [127:0] rd_val;
    logic [127:0] old_val;
    logic [31:0]  word0;
    int           pattern [6];
    req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0;
    reset = 1'b1;

    // Asynchronous reset while clk is high, no edge in between.
    #1 reset = 1'b0;
    #1;
    check_eq("reset_busy", 128'(bus5.mem_busywait), 128'(0));
    check_eq("reset_rdata", bus5.mem_readdata, 128'(0));
    check_eq("reset_err", 128'(bus5.mem_err), 128'(0));
    $display("txn reset busy=%0b rdata=%h err=%0b", bus5.mem_busywait, bus5.mem_readdata, bus5.mem_err);
    #1 reset = 1'b1;

    do_access(5, 1'b0, 1'b1, 28'h8000019, 128'h0000000D_0000000C_0000000B_0000000A, "wr_blk", rd_val);
    do_access(5, 1'b1, 1'b0, 28'h8000019, 128'h0, "rd_blk", rd_val);
    word0 = rd_val[31:0];
    check_eq("rd_word0", 128'(word0), 128'(32'h0000000A));

    do_access(5, 1'b0, 1'b1, 28'h0000019, 128'h1, "wr_alias", rd_val);
    do_access(5, 1'b1, 1'b0, 28'h8000019, 128'h0, "rd_alias", rd_val);

    do_access(5, 1'b1, 1'b1, 28'h0000002, 128'hFF, "both_req", rd_val);
    do_access(5, 1'b1, 1'b0, 28'h0000002, 128'h0, "rd_after_both", rd_val);

    // Reset two edges into a latency-5 write: the write must not land.
    old_val = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
    do_access(5, 1'b0, 1'b1, 28'h0000033, old_val, "wr_old", rd_val);
    @(negedge clk);
    req_wr = 1'b1; req_addr = 28'h0000033; req_data = ~old_val;
    repeat (3) @(posedge clk);
    #1;
    req_wr = 1'b0;
    reset  = 1'b0;
    #1;
    check_eq("midrst_busy", 128'(bus5.mem_busywait), 128'(0));
    check_eq("midrst_rdata", bus5.mem_readdata, 128'(0));
    $display("txn mid_write_reset busy=%0b rdata=%h", bus5.mem_busywait, bus5.mem_readdata);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    do_access(5, 1'b1, 1'b0, 28'h0000033, 128'h0, "rd_after_abort", rd_val);
    // The latency-1 instance finished that write before reset; realign both.
    do_access(5, 1'b0, 1'b1, 28'h0000033, old_val ^ 128'h5, "wr_resync", rd_val);

    // Back-to-back reads on the latency-1 instance with the request held.
    pattern = '{1, 1, 0, 1, 1, 0};
    @(negedge clk);
    req_rd = 1'b1; req_wr = 1'b0; req_addr = 28'h8000019;
    #1;
    check_eq("b2b_busy0", 128'(bus1.mem_busywait), 128'(pattern[0]));
    for (int c = 1; c < 6; c++) begin
      @(posedge clk); #1;
      check_eq($sformatf("b2b_busy%0d", c), 128'(bus1.mem_busywait), 128'(pattern[c]));
      if (c == 1) begin
        req_addr = 28'h0000002;
        req_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (c == 2) check_eq("b2b_rdata0", bus1.mem_readdata, model_mem[25]);
      if (c == 4) req_addr = 28'h0000033;
      if (c == 5) check_eq("b2b_rdata1", bus1.mem_readdata, model_mem[2]);
    end
    $display("txn back_to_back rdata=%h", bus1.mem_readdata);
    req_rd = 1'b0;
    repeat (10) @(posedge clk);

    // Randomised traffic; reads target written blocks through aliased addresses.
    for (int t = 0; t < 24; t++) begin
      int           lat;
      int           pick;
      logic [27:0]  a;
      logic [127:0] d;
      lat = ($urandom_range(0, 1) == 0) ? 1 : 5;
      if (written_q.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = 28'($urandom);
        d = {$urandom, $urandom, $urandom, $urandom};
        do_access(lat, 1'b0, 1'b1, a, d, $sformatf("rnd_wr%0d", t), rd_val);
      end else begin
        pick = written_q[$urandom_range(0, written_q.size() - 1)];
        a = {20'($urandom), 8'(pick)};
        do_access(lat, 1'b1, 1'b0, a, 128'h0, $sformatf("rnd_rd%0d", t), rd_val);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
